// File: rtl/psram_seq_pkg.sv
// Shared types and constants for the PSRAM access sequencer: FSM states,
// power-up opcodes and the default QPI read/write command set.
package psram_seq_pkg;

  typedef enum logic [2:0] {
    ST_POR,
    ST_INIT_RSTEN,
    ST_INIT_RST,
    ST_INIT_QPI,
    ST_IDLE,
    ST_XFER,
    ST_DRAIN
  } seq_state_e;

  localparam logic [7:0] CMD_RSTEN   = 8'h66;
  localparam logic [7:0] CMD_RST     = 8'h99;
  localparam logic [7:0] CMD_QPI     = 8'h35;
  localparam logic [7:0] DEF_RD_CMD  = 8'hEB;
  localparam logic [7:0] DEF_WR_CMD  = 8'h38;
  localparam logic [3:0] DEF_RD_WAIT = 4'd6;

  function automatic logic [7:0] init_opcode(input logic [1:0] idx);
    case (idx)
      2'd0:    init_opcode = CMD_RSTEN;
      2'd1:    init_opcode = CMD_RST;
      default: init_opcode = CMD_QPI;
    endcase
  endfunction

endpackage

// File: rtl/psram_rr_arb.sv
// Two-way round-robin arbiter: on contention the port not granted last wins;
// the history pointer moves only when a grant is actually taken.
module psram_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = req;
    last_d = last_q;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
    if (advance && (|req)) last_d = gnt[1];
  end

  // Reset value marks port 1 as last served so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/psram_access_sequencer.sv
// PSRAM front-end: replays the reset-enable/reset/enter-QPI sequence after reset,
// then serves two requesters round-robin with one QPI read or write per grant.
module psram_access_sequencer
  import psram_seq_pkg::*;
#(
  parameter int         POR_CYCLES = 16,
  parameter logic [3:0] RD_WAIT    = DEF_RD_WAIT,
  parameter logic [7:0] RD_CMD     = DEF_RD_CMD,
  parameter logic [7:0] WR_CMD     = DEF_WR_CMD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  rq_valid,
  input  logic [1:0]  rq_we,
  input  logic [47:0] rq_addr,
  input  logic [63:0] rq_wdata,
  input  logic [5:0]  rq_size,
  output logic [1:0]  rq_ready,
  output logic [31:0] rq_rdata,
  output logic        init_done,
  output logic        ctl_start,
  input  logic        ctl_done,
  output logic [23:0] ctl_addr,
  output logic [31:0] ctl_wdata,
  input  logic [31:0] ctl_rdata,
  output logic [2:0]  ctl_size,
  output logic [7:0]  ctl_cmd,
  output logic [3:0]  ctl_wait_states,
  output logic        ctl_rd_wr,
  output logic        ctl_qpi,
  output logic        ctl_qspi,
  output logic        ctl_short_cmd
);

  localparam int CNT_W = $clog2(POR_CYCLES + 1);
  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);

  function automatic logic [2:0] coerce_size(input logic [2:0] s);
    coerce_size = ((s == 3'd0) || (s > 3'd4)) ? 3'd4 : s;
  endfunction

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] por_cnt_q, por_cnt_d;
  logic [1:0]       init_idx_q, init_idx_d;
  logic             done_q;
  logic             done_rise;
  logic             gnt_q, gnt_d;
  logic             we_q, we_d;
  logic             init_done_q, init_done_d;
  logic [1:0]       rq_ready_q, rq_ready_d;
  logic [31:0]      rq_rdata_q, rq_rdata_d;
  logic             ctl_start_q, ctl_start_d;
  logic [23:0]      ctl_addr_q, ctl_addr_d;
  logic [31:0]      ctl_wdata_q, ctl_wdata_d;
  logic [2:0]       ctl_size_q, ctl_size_d;
  logic [7:0]       ctl_cmd_q, ctl_cmd_d;
  logic [3:0]       ctl_wait_q, ctl_wait_d;
  logic             ctl_rd_wr_q, ctl_rd_wr_d;
  logic             ctl_qpi_q, ctl_qpi_d;
  logic             ctl_short_q, ctl_short_d;

  logic [1:0]       arb_gnt;
  logic             launch_init;
  logic             launch_xfer;
  logic             sel;

  assign done_rise = ctl_done & ~done_q;

  psram_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rq_valid),
    .advance (launch_xfer),
    .gnt     (arb_gnt)
  );

  always_comb begin
    state_d     = state_q;
    por_cnt_d   = por_cnt_q;
    init_idx_d  = init_idx_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    init_done_d = init_done_q;
    rq_ready_d  = 2'b00;
    rq_rdata_d  = rq_rdata_q;
    ctl_start_d = 1'b0;
    ctl_addr_d  = ctl_addr_q;
    ctl_wdata_d = ctl_wdata_q;
    ctl_size_d  = ctl_size_q;
    ctl_cmd_d   = ctl_cmd_q;
    ctl_wait_d  = ctl_wait_q;
    ctl_rd_wr_d = ctl_rd_wr_q;
    ctl_qpi_d   = ctl_qpi_q;
    ctl_short_d = ctl_short_q;
    launch_init = 1'b0;
    launch_xfer = 1'b0;
    sel         = 1'b0;

    case (state_q)
      ST_POR: begin
        if (por_cnt_q == POR_LAST) begin
          state_d     = ST_INIT_RSTEN;
          init_idx_d  = 2'd0;
          launch_init = 1'b1;
        end else begin
          por_cnt_d = por_cnt_q + 1'b1;
        end
      end
      ST_INIT_RSTEN, ST_INIT_RST, ST_INIT_QPI: begin
        if (done_rise) state_d = ST_DRAIN;
      end
      ST_IDLE: begin
        if (|arb_gnt) begin
          state_d     = ST_XFER;
          launch_xfer = 1'b1;
        end
      end
      ST_XFER: begin
        if (done_rise) begin
          rq_ready_d = gnt_q ? 2'b10 : 2'b01;
          if (!we_q) rq_rdata_d = ctl_rdata;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The engine must be back at idle (done low) before anything new starts.
        if (!ctl_done) begin
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (init_idx_q == 2'd2) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
            ctl_qpi_d   = 1'b1;
            ctl_short_d = 1'b0;
          end else begin
            init_idx_d  = init_idx_q + 2'd1;
            state_d     = (init_idx_q == 2'd0) ? ST_INIT_RST : ST_INIT_QPI;
            launch_init = 1'b1;
          end
        end
      end
      default: state_d = ST_POR;
    endcase

    if (launch_init) begin
      ctl_start_d = 1'b1;
      ctl_cmd_d   = init_opcode(init_idx_d);
      ctl_short_d = 1'b1;
      ctl_qpi_d   = 1'b0;
      ctl_rd_wr_d = 1'b0;
      ctl_wait_d  = 4'd0;
      ctl_addr_d  = '0;
      ctl_wdata_d = '0;
      ctl_size_d  = '0;
    end

    if (launch_xfer) begin
      sel         = arb_gnt[1];
      gnt_d       = sel;
      we_d        = rq_we[sel];
      ctl_start_d = 1'b1;
      ctl_addr_d  = sel ? rq_addr[47:24] : rq_addr[23:0];
      ctl_wdata_d = sel ? rq_wdata[63:32] : rq_wdata[31:0];
      ctl_size_d  = coerce_size(sel ? rq_size[5:3] : rq_size[2:0]);
      ctl_cmd_d   = rq_we[sel] ? WR_CMD : RD_CMD;
      ctl_rd_wr_d = ~rq_we[sel];
      ctl_wait_d  = rq_we[sel] ? 4'd0 : RD_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_POR;
      por_cnt_q   <= '0;
      init_idx_q  <= 2'd0;
      done_q      <= 1'b0;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      init_done_q <= 1'b0;
      rq_ready_q  <= 2'b00;
      rq_rdata_q  <= '0;
      ctl_start_q <= 1'b0;
      ctl_addr_q  <= '0;
      ctl_wdata_q <= '0;
      ctl_size_q  <= '0;
      ctl_cmd_q   <= '0;
      ctl_wait_q  <= '0;
      ctl_rd_wr_q <= 1'b0;
      ctl_qpi_q   <= 1'b0;
      ctl_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      por_cnt_q   <= por_cnt_d;
      init_idx_q  <= init_idx_d;
      done_q      <= ctl_done;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      init_done_q <= init_done_d;
      rq_ready_q  <= rq_ready_d;
      rq_rdata_q  <= rq_rdata_d;
      ctl_start_q <= ctl_start_d;
      ctl_addr_q  <= ctl_addr_d;
      ctl_wdata_q <= ctl_wdata_d;
      ctl_size_q  <= ctl_size_d;
      ctl_cmd_q   <= ctl_cmd_d;
      ctl_wait_q  <= ctl_wait_d;
      ctl_rd_wr_q <= ctl_rd_wr_d;
      ctl_qpi_q   <= ctl_qpi_d;
      ctl_short_q <= ctl_short_d;
    end
  end

  assign rq_ready        = rq_ready_q;
  assign rq_rdata        = rq_rdata_q;
  assign init_done       = init_done_q;
  assign ctl_start       = ctl_start_q;
  assign ctl_addr        = ctl_addr_q;
  assign ctl_wdata       = ctl_wdata_q;
  assign ctl_size        = ctl_size_q;
  assign ctl_cmd         = ctl_cmd_q;
  assign ctl_wait_states = ctl_wait_q;
  assign ctl_rd_wr       = ctl_rd_wr_q;
  assign ctl_qpi         = ctl_qpi_q;
  assign ctl_qspi        = 1'b0;
  assign ctl_short_cmd   = ctl_short_q;

endmodule
